// File: rtl/fifo_stream_drain.sv
// Read-side drain stage: turns a fixed-latency FIFO pop interface into a
// valid/ready stream, issuing reads against credits and flagging protocol errors.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  err_missing,
  output logic                  err_unexpected,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = CNT_W + 1;

  logic [RD_LATENCY-1:0] issue_q, issue_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  missing_q, missing_d;
  logic                  unexp_q, unexp_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  logic             ret_slot;
  logic             push;
  logic             pop;
  logic             missing_ev;
  logic             unexp_ev;
  logic [OCC_W-1:0] inflight;
  logic [OCC_W-1:0] occupancy;

  assign ret_slot = issue_q[RD_LATENCY-1];
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid & m_ready;
  assign push     = ret_slot & fifo_data_valid;
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;

  assign missing_ev = ret_slot & ~fifo_data_valid;
  assign unexp_ev   = ~ret_slot & fifo_data_valid;

  assign err_missing    = missing_q;
  assign err_unexpected = unexp_q;
  assign err_count      = err_cnt_q;

  // Credits: beats already buffered plus reads still in the memory pipeline,
  // less the beat leaving this cycle, must stay below the buffer depth.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(issue_q[i]);
    end
  end

  // pop implies count_q >= 1, so the subtraction never underflows.
  assign occupancy = OCC_W'(count_q) + inflight - OCC_W'(pop);
  assign fifo_re   = rst_n & ~fifo_empty & (occupancy < OCC_W'(BUF_DEPTH));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    issue_d   = (issue_q << 1) | RD_LATENCY'(fifo_re);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    missing_d = missing_q | missing_ev;
    unexp_d   = unexp_q | unexp_ev;
    err_cnt_d = err_cnt_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    // The two error events are mutually exclusive, so one increment covers both.
    if ((missing_ev || unexp_ev) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      missing_q <= 1'b0;
      unexp_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      issue_q   <= issue_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      missing_q <= missing_d;
      unexp_q   <= unexp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q gates visibility, and m_data is
  // forced to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: FIFO + latency model, queue-based reference of
// the output buffer, directed vectors and randomized traffic.
module tb_fifo_stream_drain;

  localparam int DW = 8;
  localparam int RL = 2;
  localparam int BD = RL + 1;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_re;
  logic [DW-1:0] fifo_data;
  logic          fifo_data_valid;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          err_missing;
  logic          err_unexpected;
  logic [EW-1:0] err_count;

  fifo_stream_drain #(.DATA_WIDTH(DW), .RD_LATENCY(RL), .ERR_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_missing(err_missing), .err_unexpected(err_unexpected),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    bit          drop;
  } pend_t;

  typedef struct {
    logic          m_ready;
    logic          exp_re;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fifo_q[$];
  pend_t         pending[$];
  logic [DW-1:0] exp_buf[$];
  logic [DW-1:0] out_q[$];
  bit            cur_ret = 0;
  int            cyc = 0;
  int            n_reads = 0;
  int            drop_read = -1;
  bit            exp_missing = 0;
  bit            exp_unexp = 0;
  int            exp_err = 0;

  logic          s_re, s_valid;
  logic [DW-1:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void note_error();
    if (exp_err < 255) exp_err++;
  endfunction

  // One clock cycle: called and returning at posedge+1. Samples the DUT mid-
  // cycle, compares against the reference, applies the edge, drives new inputs.
  task automatic tick();
    int    infl;
    bit    pop;
    bit    exp_re;
    pend_t pe;
    @(negedge clk);
    s_re    = fifo_re;
    s_valid = m_valid;
    s_data  = m_data;
    pop    = (exp_buf.size() != 0) && m_ready;
    infl   = pending.size() + (cur_ret ? 1 : 0);
    exp_re = !fifo_empty && ((exp_buf.size() + infl - (pop ? 1 : 0)) < BD);
    check("fifo_re", s_re, exp_re);
    check("m_valid", s_valid, exp_buf.size() != 0);
    if (exp_buf.size() != 0) check("m_data", s_data, exp_buf[0]);
    check("err_missing", err_missing, exp_missing);
    check("err_unexpected", err_unexpected, exp_unexp);
    check("err_count", err_count, exp_err);

    if (s_valid && m_ready) out_q.push_back(s_data);
    if (pop) void'(exp_buf.pop_front());
    if (cur_ret && fifo_data_valid) begin
      check("buf_overflow", exp_buf.size() < BD, 1);
      exp_buf.push_back(fifo_data);
    end else if (cur_ret) begin
      exp_missing = 1;
      note_error();
    end else if (fifo_data_valid) begin
      exp_unexp = 1;
      note_error();
    end
    if (s_re) begin
      if (fifo_q.size() == 0) begin
        check("over_read", 1, 0);
      end else begin
        pe.data = fifo_q.pop_front();
        pe.due  = cyc + RL;
        pe.drop = (n_reads == drop_read);
        pending.push_back(pe);
        n_reads++;
      end
    end
    cyc++;

    @(posedge clk);
    #1;
    cur_ret         = 0;
    fifo_data_valid = 1'b0;
    fifo_data       = DW'($urandom);
    if (pending.size() != 0 && pending[0].due == cyc) begin
      pe              = pending.pop_front();
      cur_ret         = 1;
      fifo_data       = pe.data;
      fifo_data_valid = !pe.drop;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic fifo_push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  function automatic bit busy();
    return fifo_q.size() != 0 || pending.size() != 0 || exp_buf.size() != 0 || cur_ret;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (busy() && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   re_cnt, streak, max_streak, errs, n;
    logic [DW-1:0] d;

    // First beat appears RL+1 cycles after the first read; one beat per cycle.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h22};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h33};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00};

    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    fifo_data_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_fifo_re", fifo_re, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_flags", {err_missing, err_unexpected}, 0);
    rst_n = 1'b1;

    // Directed three-word transfer.
    fifo_push(8'h11);
    fifo_push(8'h22);
    fifo_push(8'h33);
    for (int i = 0; i < 7; i++) begin
      m_ready = vecs[i].m_ready;
      tick();
      check($sformatf("vec%0d_re", i), s_re, vecs[i].exp_re);
      check($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
    end
    check("vec_err_count", err_count, 0);

    // Sustained streaming of 256 incrementing bytes.
    out_q.delete();
    for (int i = 0; i < 256; i++) fifo_push(DW'(i));
    m_ready = 1'b1;
    streak = 0;
    max_streak = 0;
    n = 0;
    while (busy() && n < 1000) begin
      tick();
      n++;
      if (s_valid) streak++;
      else begin
        if (streak > max_streak) max_streak = streak;
        streak = 0;
      end
    end
    if (streak > max_streak) max_streak = streak;
    if (n >= 1000) check("stream_timeout", 0, 1);
    check("stream_run_len", max_streak, 256);
    check("stream_count", out_q.size(), 256);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== DW'(i)) errs++;
    check("stream_order", errs, 0);

    // Backpressure: reads stop at BD credits, head word held.
    out_q.delete();
    for (int i = 0; i < 5; i++) fifo_push(8'h51 + DW'(i));
    m_ready = 1'b0;
    re_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_re) re_cnt++;
    end
    check("bp_re_count", re_cnt, BD);
    check("bp_head_valid", s_valid, 1);
    check("bp_head_data", s_data, 8'h51);
    m_ready = 1'b1;
    drain("bp");
    check("bp_count", out_q.size(), 5);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'h51 + DW'(i)) errs++;
    check("bp_order", errs, 0);

    // Randomized traffic and backpressure.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 20) fifo_push(DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_ready = 1'b1;
    drain("rand");

    // Missing beat: second read of three returns without valid.
    out_q.delete();
    drop_read = n_reads + 1;
    fifo_push(8'h61);
    fifo_push(8'h62);
    fifo_push(8'h63);
    drain("miss");
    check("miss_flag", err_missing, 1);
    check("miss_count", err_count, 1);
    check("miss_out_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      check("miss_out0", out_q[0], 8'h61);
      check("miss_out1", out_q[1], 8'h63);
    end

    // Unexpected valid while idle, then saturation of the counter.
    repeat (2) tick();
    fifo_data = 8'hEE;
    fifo_data_valid = 1'b1;
    repeat (3) tick();
    check("unexp_flag", err_unexpected, 1);
    check("unexp_count", err_count, 2);
    check("unexp_buf_empty", m_valid, 0);
    for (int i = 0; i < 260; i++) begin
      fifo_data_valid = 1'b1;
      tick();
    end
    tick();
    check("err_saturate", err_count, 255);

    // Asynchronous reset with two beats buffered.
    out_q.delete();
    for (int i = 0; i < 8; i++) fifo_push(8'h80 + DW'(i));
    m_ready = 1'b0;
    n = 0;
    while (exp_buf.size() != 2 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("rst_fill_timeout", 0, 1);
    check("pre_rst_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_fifo_re", fifo_re, 0);
    check("arst_m_data", m_data, 0);
    check("arst_err_count", err_count, 0);
    check("arst_err_flags", {err_missing, err_unexpected}, 0);
    fifo_q.delete();
    pending.delete();
    exp_buf.delete();
    cur_ret = 0;
    exp_missing = 0;
    exp_unexp = 0;
    exp_err = 0;
    fifo_empty = 1'b1;
    fifo_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", m_valid, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    fifo_push(8'hA0);
    fifo_push(8'hA1);
    m_ready = 1'b1;
    drain("post_rst");
    check("post_rst_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      check("post_rst_out0", out_q[0], 8'hA0);
      check("post_rst_out1", out_q[1], 8'hA1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Downstream read-side stage for the synchronous valid-checking FIFO.
- Converts the FIFO's pop interface (re / rdata / data_valid / empty) into a valid/ready output stream, 1 beat/cycle sustained.
- Hides the fixed memory read latency using credit-based read issue and a small output buffer.
- Checks that each issued read returns a valid beat in its expected slot, and counts protocol errors.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and output data.
- RD_LATENCY, 1, cycles from fifo_re high to fifo_data/fifo_data_valid presented; legal range 1..4.
- BUF_DEPTH, RD_LATENCY+1, output buffer entries; derived, not overridden.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  FIFO read enable (pop).
- fifo_data  input  DATA_WIDTH  FIFO read data.
- fifo_data_valid  input  1  FIFO read-data valid.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  output beat data; equals the buffer head entry.
- err_missing  output  1  sticky flag: an expected beat returned with fifo_data_valid low.
- err_unexpected  output  1  sticky flag: fifo_data_valid high in a slot with no read issued.
- err_count  output  ERR_WIDTH  saturating count of all error events.

Behaviour:
- Reset (async assert, sync-style deassert on next posedge):
  - Clears fifo_re, m_valid, m_data, err_missing, err_unexpected, err_count, buffer pointers/count and in-flight tracker.
  - Reset mid-operation discards buffered and in-flight beats.
- Credits: inflight = number of 1s in an RD_LATENCY-bit shift register; bit 0 is loaded with fifo_re each cycle and bit RD_LATENCY-1 marks the return slot.
- Read issue (combinational):
  - fifo_re = ~fifo_empty & ((buf_count + inflight - pop) < BUF_DEPTH), where pop = m_valid & m_ready.
  - FIFO updates empty on the same edge that samples fifo_re, so there is no over-read.
- Return slot, i.e. shift-register MSB = 1:
  - fifo_data_valid = 1: write fifo_data into the buffer tail.
  - fifo_data_valid = 0: no write; set err_missing; err_count += 1.
- Non-return slot with fifo_data_valid = 1: no write; set err_unexpected; err_count += 1.
- Error counting:
  - err_count saturates at all-ones.
  - At most one increment per cycle.
  - Error flags stay set until reset.
- Output:
  - m_valid = (buf_count != 0), registered state.
  - m_data is the head entry.
  - Head entry is held stable while m_valid & ~m_ready.
- Buffer: circular, BUF_DEPTH entries.
  - Simultaneous push and pop in the same cycle leaves buf_count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Push into a full buffer cannot occur by construction; the bench asserts this.
- Latency: first beat shows m_valid = 1 at RD_LATENCY+1 cycles after fifo_re (re cycle N, data cycle N+RD_LATENCY, captured edge, m_valid cycle N+RD_LATENCY+1).
- Throughput: with m_ready held high and FIFO non-empty, fifo_re stays high every cycle and m_valid stays high continuously after fill.
- Backpressure: m_ready low stops reads once buf_count + inflight reaches BUF_DEPTH; no beat is lost or duplicated.

Test Plan:
- Reset, then push 0x11,0x22,0x33 into the FIFO with m_ready = 1 → fifo_re high for 3 cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting RD_LATENCY+1 after first re; err_count = 0.
- Continuous streaming of 256 incrementing bytes with m_ready = 1 → m_valid high 256 consecutive cycles after fill; data in order.
- m_ready = 0 for 10 cycles with 5 words in the FIFO → fifo_re asserted exactly BUF_DEPTH times; m_data held at the first word; release → all 5 words emitted in order.
- Force fifo_data_valid = 0 on one return slot → that beat is dropped; err_missing = 1; err_count = 1; the following beat is still delivered.
- Pulse fifo_data_valid = 1 while idle → err_unexpected = 1; err_count increments; buffer is unchanged.
- Assert rst_n = 0 asynchronously mid-stream with 2 beats buffered → m_valid, fifo_re and counters are 0 immediately without a clock edge; stale beats are never emitted after release.
